// File: rtl/qdma_stm_pkg.sv
// Shared types for the QDMA stream egress path: packet FSM states and the
// per-packet status record reported once a packet leaves the block.
package qdma_stm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PKT  = 2'd1,
        ST_DROP = 2'd2
    } state_e;

    localparam int STAT_BEATS_W = 16;

    typedef struct packed {
        logic [STAT_BEATS_W-1:0] beats;
        logic                    trunc;
    } stat_t;

endpackage

// File: rtl/qdma_axis_skid.sv
// Two-entry skid buffer with registered outputs and registered ready.
// Latency 1 cycle when empty; ready drops only once both entries are occupied.
module qdma_axis_skid #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_dat_i,
    input  logic         in_vld_i,
    output logic         in_rdy_o,
    output logic [W-1:0] out_dat_o,
    output logic         out_vld_o,
    input  logic         out_rdy_i
);

    logic [W-1:0] main_q, main_d, skid_q, skid_d;
    logic         main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
    logic         rdy_q;
    logic         push, pop;

    assign push = in_vld_i && rdy_q;
    assign pop  = main_vld_q && out_rdy_i;

    always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (!main_vld_q || pop) begin
            // Output slot frees up: the older skid entry must go first.
            if (skid_vld_q) begin
                main_d     = skid_q;
                main_vld_d = 1'b1;
                skid_d     = push ? in_dat_i : skid_q;
                skid_vld_d = push;
            end else begin
                main_d     = push ? in_dat_i : main_q;
                main_vld_d = push;
            end
        end else if (push) begin
            skid_d     = in_dat_i;
            skid_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_q     <= '0;
            main_vld_q <= 1'b0;
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
            rdy_q      <= 1'b0;
        end else begin
            main_q     <= main_d;
            main_vld_q <= main_vld_d;
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
            rdy_q      <= !skid_vld_d;
        end
    end

    assign in_rdy_o  = rdy_q;
    assign out_dat_o = main_q;
    assign out_vld_o = main_vld_q;

endmodule

// File: rtl/qdma_stm_axis_egress.sv
// Packet egress onto AXI-Stream: counts beats, truncates at MAX_BEATS and drops the tail.
// Latency 1 cycle through a 2-entry skid; ready follows skid space, forced high while dropping.
module qdma_stm_axis_egress
    import qdma_stm_pkg::*;
#(
    parameter int DATA_BITS = 128,
    parameter int SB_BITS   = 5,
    parameter int MAX_BEATS = 64,
    parameter int BCNT_BITS = $clog2(MAX_BEATS + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic [SB_BITS-1:0]   in_sb,
    input  logic                 in_last,
    input  logic                 in_vld,
    output logic                 in_rdy,
    output logic [DATA_BITS-1:0] m_tdata,
    output logic [SB_BITS-1:0]   m_tuser,
    output logic                 m_tlast,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic                 stat_vld,
    output logic [BCNT_BITS-1:0] stat_beats,
    output logic                 stat_trunc,
    output logic [15:0]          pkt_cnt
);

    localparam int PW = DATA_BITS + SB_BITS + 1;

    state_e               state_q, state_d;
    logic [BCNT_BITS-1:0] cnt_q, cnt_d, cnt_inc;
    stat_t                stat_q, stat_d;
    logic                 stat_vld_q, emit;
    logic [15:0]          pkt_cnt_q;
    logic                 skid_rdy, acc, fwd, force_last;
    logic                 unused_stat_hi;

    assign in_rdy  = skid_rdy || (state_q == ST_DROP);
    assign acc     = in_vld && in_rdy;
    assign cnt_inc = cnt_q + BCNT_BITS'(1);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stat_d     = stat_q;
        fwd        = 1'b0;
        force_last = 1'b0;
        emit       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (acc) begin
                    fwd   = 1'b1;
                    cnt_d = BCNT_BITS'(1);
                    if (in_last) begin
                        emit   = 1'b1;
                        stat_d = '{beats: STAT_BEATS_W'(1), trunc: 1'b0};
                    end else begin
                        state_d = ST_PKT;
                    end
                end
            end
            ST_PKT: begin
                if (acc) begin
                    fwd   = 1'b1;
                    cnt_d = cnt_inc;
                    if (in_last) begin
                        emit    = 1'b1;
                        stat_d  = '{beats: STAT_BEATS_W'(cnt_inc), trunc: 1'b0};
                        state_d = ST_IDLE;
                    end else if (cnt_inc == BCNT_BITS'(MAX_BEATS)) begin
                        // Close the packet downstream and swallow the rest of it.
                        force_last = 1'b1;
                        emit       = 1'b1;
                        stat_d     = '{beats: STAT_BEATS_W'(cnt_inc), trunc: 1'b1};
                        state_d    = ST_DROP;
                    end
                end
            end
            ST_DROP: begin
                if (acc && in_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            stat_q     <= '0;
            stat_vld_q <= 1'b0;
            pkt_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            stat_q     <= stat_d;
            stat_vld_q <= emit;
            if (emit && (pkt_cnt_q != 16'hFFFF)) begin
                pkt_cnt_q <= pkt_cnt_q + 16'd1;
            end
        end
    end

    qdma_axis_skid #(
        .W (PW)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_dat_i  ({in_last | force_last, in_sb, in_data}),
        .in_vld_i  (fwd),
        .in_rdy_o  (skid_rdy),
        .out_dat_o ({m_tlast, m_tuser, m_tdata}),
        .out_vld_o (m_tvalid),
        .out_rdy_i (m_tready)
    );

    // Beat counts never exceed BCNT_BITS, so the wider status field's top bits stay zero.
    assign unused_stat_hi = |(stat_q.beats >> BCNT_BITS);

    assign stat_vld   = stat_vld_q;
    assign stat_beats = stat_q.beats[BCNT_BITS-1:0];
    assign stat_trunc = stat_q.trunc;
    assign pkt_cnt    = pkt_cnt_q;

endmodule

// File: doc/qdma_stm_axis_egress.md
QDMA_STM_AXIS_EGRESS -- requirements
Module: qdma_stm_axis_egress

Interface
REQ-001 SHALL have parameter DATA_BITS, default 128: payload width per beat.
REQ-002 SHALL have parameter SB_BITS, default 5: sideband width per beat.
REQ-003 SHALL have parameter MAX_BEATS, default 64: maximum beats per packet; MAX_BEATS >= 2.
REQ-004 SHALL have parameter BCNT_BITS, default $clog2(MAX_BEATS+1): beat-count width.
REQ-005 SHALL have ports as follows (clock and reset first):
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- in_data  in  DATA_BITS  beat payload from the upstream LUT FIFO
- in_sb  in  SB_BITS  beat sideband
- in_last  in  1  last beat of packet
- in_vld  in  1  upstream valid
- in_rdy  out  1  ready to upstream
- m_tdata  out  DATA_BITS  AXI-Stream data
- m_tuser  out  SB_BITS  AXI-Stream user (carries sideband)
- m_tlast  out  1  AXI-Stream last
- m_tvalid  out  1  AXI-Stream valid
- m_tready  in  1  AXI-Stream ready
- stat_vld  out  1  one-cycle packet-status pulse
- stat_beats  out  BCNT_BITS  beats forwarded for the packet
- stat_trunc  out  1  packet was truncated
- pkt_cnt  out  16  packets forwarded, saturating

Function
REQ-006 A beat SHALL transfer at the input only when in_vld && in_rdy; at the output only when m_tvalid && m_tready.
REQ-007 The output path SHALL be a 2-entry skid buffer; all m_* outputs SHALL be driven from registers.
REQ-008 A forwarded beat SHALL appear on m_* in the cycle after its input acceptance when the buffer is empty; latency is 1 cycle.
REQ-009 in_rdy SHALL be registered and high whenever at least one skid entry is free at the start of the cycle.
REQ-010 Sustained in_vld and m_tready SHALL give 1 beat per cycle.
REQ-011 Once m_tvalid is asserted, m_tdata, m_tuser and m_tlast SHALL hold stable until the output handshake completes.
REQ-012 The FSM SHALL have three states: IDLE (between packets), PKT (mid-packet) and DROP (discarding the tail of a truncated packet).
REQ-013 IDLE with an accepted beat: beat_cnt <= 1. If in_last, stay in IDLE and emit status; otherwise go to PKT.
REQ-014 PKT with an accepted beat: beat_cnt increments by 1. If in_last, return to IDLE and emit status.
REQ-015 Truncation in PKT: if an accepted beat would make beat_cnt == MAX_BEATS with in_last=0, then:
- forward that beat with m_tlast forced to 1;
- emit status with stat_trunc=1;
- go to DROP.
REQ-016 A beat with in_last=1 arriving exactly at MAX_BEATS SHALL NOT be treated as truncated.
REQ-017 DROP SHALL hold in_rdy=1 regardless of skid occupancy and SHALL discard accepted beats (not forwarded, not counted).
REQ-018 DROP SHALL return to IDLE on an accepted beat with in_last=1, with no status emitted.
REQ-019 Status SHALL be registered:
- stat_vld pulses one cycle after the input acceptance of the forwarded tlast beat;
- stat_beats equals the forwarded beat count;
- stat_beats and stat_trunc hold their values until the next pulse.
REQ-020 pkt_cnt SHALL increment on each stat_vld and saturate at 16'hFFFF.
REQ-021 Simultaneous input and output handshakes with the buffer full SHALL leave occupancy unchanged with no beat lost.
REQ-022 When MAX_BEATS is reached, beat_cnt SHALL NOT wrap.

Reset
REQ-023 While rst_n=0 at a clk edge, the following SHALL clear to 0: in_rdy, m_tvalid, m_tdata, m_tuser, m_tlast, stat_vld, stat_beats, stat_trunc, pkt_cnt, beat_cnt, and skid occupancy; the FSM SHALL go to IDLE.
REQ-024 in_rdy SHALL rise in the first cycle after rst_n deasserts.
REQ-025 Reset mid-packet SHALL discard buffered beats; the next accepted beat SHALL start a new packet.

Structure
REQ-026 A shared package qdma_stm_pkg SHALL hold the FSM state enum (IDLE/PKT/DROP) and a packed status struct {beats, trunc}.
REQ-027 The skid buffer SHALL be a sub-module qdma_axis_skid, parameterised on payload width (DATA_BITS+SB_BITS+1).
REQ-028 The implementation SHALL be sized at 150-300 lines of RTL total.

Verification
REQ-029 Single 1-beat packet (in_last=1), m_tready=1 -> m_tvalid the next cycle with m_tlast=1; stat_vld with stat_beats=1, stat_trunc=0; pkt_cnt=1.
REQ-030 Back-to-back 4-beat packets, m_tready=1 -> 8 consecutive output beats with m_tlast on beats 4 and 8; two status pulses, each stat_beats=4.
REQ-031 m_tready low for 5 cycles mid-stream -> in_rdy drops after 2 buffered beats; data held stable; no beats lost or duplicated after release.
REQ-032 MAX_BEATS=4, 7-beat packet -> 4 beats forwarded with m_tlast on beat 4; stat_trunc=1, stat_beats=4; beats 5-7 discarded; the next packet is forwarded intact.
REQ-033 MAX_BEATS=4, 4-beat packet with in_last on beat 4 -> stat_trunc=0, no DROP entry.
REQ-034 rst_n asserted with 2 beats buffered in the middle of a packet -> m_tvalid=0 the next cycle; the following 2-beat packet yields stat_beats=2.
